// File: rtl/lvds_tx_stream_arbiter.sv
// Shares the 8-bit LVDS TX word stream between the alignment pattern and user data; sequences bring-up and realigns at frame boundaries.
// Latency: one cycle from accepted user word (or alignment state) to O_valid/O_data; O_user_ready is combinational from state.
// Backpressure: ready is held low outside USER/WAIT_EOF; the serializer side has no stall, so words are never held.
module lvds_tx_stream_arbiter #(
    parameter logic [7:0]  ALIGN_WORD     = 8'hF0,
    parameter logic [7:0]  IDLE_WORD      = 8'h00,
    parameter int unsigned ALIGN_CYCLES   = 64,
    parameter int unsigned REALIGN_PERIOD = 65536
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_enable,
    input  logic       I_align_req,
    input  logic       I_user_valid,
    input  logic [7:0] I_user_data,
    input  logic       I_user_last,
    output logic       O_user_ready,
    output logic       O_valid,
    output logic [7:0] O_data,
    output logic       O_aligning,
    output logic [1:0] O_state
);

    localparam int unsigned AW = $clog2(ALIGN_CYCLES + 1);
    localparam int unsigned PW = (REALIGN_PERIOD > 0) ? $clog2(REALIGN_PERIOD + 1) : 1;
    localparam logic [AW-1:0] ALIGN_LAST   = AW'(ALIGN_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_MAX   = PW'((REALIGN_PERIOD > 0) ? (REALIGN_PERIOD - 1) : 0);
    localparam bit            AUTO_REALIGN = (REALIGN_PERIOD > 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_ALIGN    = 2'b01,
        S_USER     = 2'b10,
        S_WAIT_EOF = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          in_frame_q, in_frame_d;
    logic          pending_q, pending_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          aligning_q, aligning_d;

    logic user_st;
    logic accept;
    logic period_hit;
    logic pend_now;
    logic frame_after;

    assign user_st      = (state_q == S_USER) || (state_q == S_WAIT_EOF);
    assign accept       = I_user_valid & user_st;
    assign period_hit   = AUTO_REALIGN && user_st && (pcnt_q == PERIOD_MAX);
    // A request or expiry this cycle counts immediately, so the burst is not delayed a cycle.
    assign pend_now     = pending_q | (user_st & I_align_req) | period_hit;
    assign frame_after  = accept ? ~I_user_last : in_frame_q;

    always_comb begin
        state_d    = state_q;
        acnt_d     = acnt_q;
        pcnt_d     = pcnt_q;
        in_frame_d = frame_after;
        pending_d  = user_st ? pend_now : pending_q;
        valid_d    = 1'b0;
        data_d     = IDLE_WORD;
        aligning_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (I_enable) state_d = S_ALIGN;
            end
            S_ALIGN: begin
                if (!I_enable) begin
                    state_d = S_IDLE;
                end else begin
                    valid_d    = 1'b1;
                    data_d     = ALIGN_WORD;
                    aligning_d = 1'b1;
                    acnt_d     = acnt_q + AW'(1);
                    if (acnt_q == ALIGN_LAST) state_d = S_USER;
                end
            end
            S_USER: begin
                valid_d = accept;
                if (accept) data_d = I_user_data;
                if (pend_now || !I_enable) begin
                    if (frame_after)   state_d = S_WAIT_EOF;
                    else if (I_enable) state_d = S_ALIGN;
                    else               state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = accept;
                if (accept) data_d = I_user_data;
                if (accept && I_user_last) state_d = I_enable ? S_ALIGN : S_IDLE;
            end
        endcase

        if (AUTO_REALIGN && user_st && (pcnt_q != PERIOD_MAX)) pcnt_d = pcnt_q + PW'(1);

        // Every burst starts from a clean count and consumes any outstanding request.
        if ((state_d == S_ALIGN) && (state_q != S_ALIGN)) begin
            acnt_d    = '0;
            pcnt_d    = '0;
            pending_d = 1'b0;
        end
        if ((state_d == S_IDLE) && (state_q != S_IDLE)) in_frame_d = 1'b0;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= S_IDLE;
            acnt_q     <= '0;
            pcnt_q     <= '0;
            in_frame_q <= 1'b0;
            pending_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= IDLE_WORD;
            aligning_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acnt_q     <= acnt_d;
            pcnt_q     <= pcnt_d;
            in_frame_q <= in_frame_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            aligning_q <= aligning_d;
        end
    end

    assign O_user_ready = user_st;
    assign O_valid      = valid_q;
    assign O_data       = data_q;
    assign O_aligning   = aligning_q;
    assign O_state      = state_q;

endmodule

// File: tb/tb_lvds_tx_stream_arbiter.sv
// Bench for lvds_tx_stream_arbiter: two instances (periodic realign 16 and disabled) against a cycle-level reference model.
module tb_lvds_tx_stream_arbiter;

    localparam int A_CYC = 4;

    logic       clk;
    logic       rst_n;
    logic       en, req, uv, ul;
    logic [7:0] ud;

    logic       a_rdy, a_vld, a_aln;
    logic [7:0] a_dat;
    logic [1:0] a_st;
    logic       b_rdy, b_vld, b_aln;
    logic [7:0] b_dat;
    logic [1:0] b_st;

    int vectors = 0;
    int errors  = 0;

    lvds_tx_stream_arbiter #(.ALIGN_CYCLES(A_CYC), .REALIGN_PERIOD(16)) dut_a (
        .I_clk(clk), .I_rst_n(rst_n), .I_enable(en), .I_align_req(req),
        .I_user_valid(uv), .I_user_data(ud), .I_user_last(ul),
        .O_user_ready(a_rdy), .O_valid(a_vld), .O_data(a_dat),
        .O_aligning(a_aln), .O_state(a_st)
    );

    lvds_tx_stream_arbiter #(.ALIGN_CYCLES(A_CYC), .REALIGN_PERIOD(0)) dut_b (
        .I_clk(clk), .I_rst_n(rst_n), .I_enable(en), .I_align_req(req),
        .I_user_valid(uv), .I_user_data(ud), .I_user_last(ul),
        .O_user_ready(b_rdy), .O_valid(b_vld), .O_data(b_dat),
        .O_aligning(b_aln), .O_state(b_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // phase: 0 idle, 1 burst, 2 user, 3 draining a frame before realign/stop
    typedef struct packed {
        int         phase;
        int         burst_left;
        int         resid;
        bit         frame;
        bit         pend;
        bit         vld;
        logic [7:0] dat;
        bit         aln;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m = '0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int period, bit e, bit r, bit v, logic [7:0] d, bit l);
        mdl_t n;
        bit   acc;
        int   target;
        n      = m;
        acc    = v && (m.phase >= 2);
        target = -1;
        n.vld  = 1'b0;
        n.dat  = 8'h00;
        n.aln  = 1'b0;
        if (m.phase == 0) begin
            if (e) target = 1;
        end else if (m.phase == 1) begin
            if (!e) target = 0;
            else begin
                n.vld = 1'b1; n.dat = 8'hF0; n.aln = 1'b1;
                n.burst_left = n.burst_left - 1;
                if (n.burst_left == 0) n.phase = 2;
            end
        end else begin
            if (acc) begin n.vld = 1'b1; n.dat = d; n.frame = !l; end
            n.resid = n.resid + 1;
            if (r || (period > 0 && n.resid >= period)) n.pend = 1'b1;
            if (m.phase == 2) begin
                if (n.pend || !e) begin
                    if (n.frame) n.phase = 3;
                    else         target = e ? 1 : 0;
                end
            end else if (acc && l) begin
                target = e ? 1 : 0;
            end
        end
        if (target == 1) begin
            n.phase = 1; n.burst_left = A_CYC; n.pend = 1'b0; n.resid = 0;
        end else if (target == 0) begin
            n.phase = 0; n.frame = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_valid", 32'(a_vld), 32'(ma.vld));
        chk("a_data",  32'(a_dat), 32'(ma.dat));
        chk("a_align", 32'(a_aln), 32'(ma.aln));
        chk("a_state", 32'(a_st),  32'(ma.phase));
        chk("a_ready", 32'(a_rdy), 32'(ma.phase >= 2));
        chk("b_valid", 32'(b_vld), 32'(mb.vld));
        chk("b_data",  32'(b_dat), 32'(mb.dat));
        chk("b_align", 32'(b_aln), 32'(mb.aln));
        chk("b_state", 32'(b_st),  32'(mb.phase));
        chk("b_ready", 32'(b_rdy), 32'(mb.phase >= 2));
    endtask

    task automatic tick();
        ma = mstep(ma, 16, en, req, uv, ud, ul);
        mb = mstep(mb, 0,  en, req, uv, ud, ul);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic step(bit e, bit r, bit v, logic [7:0] d, bit l);
        en = e; req = r; uv = v; ud = d; ul = l;
        tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b1; en = 0; req = 0; uv = 0; ud = 8'h00; ul = 0;
        ma = mreset(); mb = mreset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // bring-up: one IDLE->ALIGN cycle, then exactly four alignment words
        step(1, 0, 0, 8'h00, 0);
        chk("bringup_state", 32'(a_st), 32'd1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 8'h00, 0);
            if (a_aln && a_dat == 8'hF0 && a_vld) n++;
        end
        chk("burst_len", n, 32'd4);
        chk("ready_after_burst", 32'(a_rdy), 32'd1);

        // frame 11,22,gap,33(last)
        step(1, 0, 1, 8'h11, 0);
        chk("word11", 32'(a_dat), 32'h11);
        step(1, 0, 1, 8'h22, 0);
        step(1, 0, 0, 8'h00, 0);
        chk("gap_valid", 32'(a_vld), 32'd0);
        chk("gap_data", 32'(a_dat), 32'h00);
        step(1, 0, 1, 8'h33, 1);

        // request mid-frame: drain to last word, then burst
        step(1, 0, 1, 8'h44, 0);
        step(1, 1, 0, 8'h00, 0);
        chk("req_wait_eof", 32'(a_st), 32'd3);
        step(1, 0, 1, 8'h55, 0);
        step(1, 0, 1, 8'h66, 1);
        chk("eof_ready_drop", 32'(a_rdy), 32'd0);
        chk("eof_last_word", 32'(a_dat), 32'h66);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 8'h00, 0);
            if (a_aln) n++;
        end
        chk("req_burst_len", n, 32'd4);

        // automatic realign after 16 idle USER cycles
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_st != 2'b10) break;
            n++;
            step(1, 0, 0, 8'h00, 0);
        end
        chk("period16_residence", n, 32'd16);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h00, 0);

        // disabled period: no burst on instance B
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1, 0, 0, 8'h00, 0);
            if (b_aln) n++;
        end
        chk("no_auto_realign", n, 32'd0);
        chk("b_stays_user", 32'(b_st), 32'd2);

        // enable dropped in the second ALIGN cycle
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0);
        chk("disabled_idle", 32'(a_st), 32'd0);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        chk("abort_state", 32'(a_st), 32'd0);
        chk("abort_valid", 32'(a_vld), 32'd0);

        // enable dropped mid-frame: frame completes then IDLE without a burst
        for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h00, 0);
        step(1, 0, 1, 8'h77, 0);
        step(0, 0, 1, 8'h88, 0);
        chk("drop_wait_eof", 32'(a_st), 32'd3);
        step(0, 0, 1, 8'h99, 1);
        chk("drop_idle", 32'(a_st), 32'd0);
        chk("drop_last_word", 32'(a_dat), 32'h99);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 8'h00, 0);
            if (a_aln) n++;
        end
        chk("drop_no_burst", n, 32'd0);

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(a_vld), 32'd0);
        chk("arst_data", 32'(a_dat), 32'h00);
        chk("arst_align", 32'(a_aln), 32'd0);
        chk("arst_state", 32'(a_st), 32'd0);
        chk("arst_ready", 32'(a_rdy), 32'd0);
        ma = mreset(); mb = mreset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 8'h00, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 8'h00, 0);
            if (a_aln) n++;
        end
        chk("post_reset_burst", n, 32'd4);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
